// File: rtl/tri_st_popcnt_pipe.sv
// Two-stage pipelined population count (popcntb/popcntw/popcntd) with valid/ready, tag and flush.
// Optional macro TRI_POPCNT_PRTY_EN turns mode 11 into prtyw; otherwise mode 11 returns zero.
`timescale 1ns/1ps
module tri_st_popcnt_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6
) (
    input  logic             nclk,
    input  logic             rst_n,
    inout  wire              vdd,
    inout  wire              gnd,
    input  logic             i_val,
    output logic             i_rdy,
    input  logic [1:0]       i_mode,
    input  logic [0:WIDTH-1] i_data,
    input  logic [0:TAG_W-1] i_tag,
    input  logic             flush,
    output logic             o_val,
    input  logic             o_rdy,
    output logic [0:WIDTH-1] o_data,
    output logic [0:TAG_W-1] o_tag
);
    localparam int NB = WIDTH / 8;
    localparam int NW = WIDTH / 32;
    localparam int ND = WIDTH / 64;

    logic             s1_val_reg, s1_val_next;
    logic             o_val_reg, o_val_next;
    logic [1:0]       s1_mode_reg;
    logic [0:TAG_W-1] s1_tag_reg, o_tag_reg;
    logic [0:WIDTH-1] o_data_reg, res_next;
    logic             s2_adv, s1_adv, in_fire, s1_move;

    logic [0:4*NB-1]  cnt_flat;
    logic [0:6*NW-1]  wsum_flat;
    logic [0:7*ND-1]  dsum_flat;
`ifdef TRI_POPCNT_PRTY_EN
    logic [0:NB-1]    par_flat;
`endif

    // Power pins are present for the physical netlist only.
    logic unused_pwr;
    assign unused_pwr = vdd ^ gnd;

    assign s2_adv  = !o_val_reg | o_rdy;
    assign s1_adv  = !s1_val_reg | s2_adv;
    assign i_rdy   = s1_adv & !flush & rst_n;
    assign in_fire = i_val & i_rdy;
    assign s1_move = s2_adv & s1_val_reg & !flush;

    always_comb begin
        s1_val_next = s1_val_reg;
        o_val_next  = o_val_reg;
        if (flush) begin
            s1_val_next = 1'b0;
            o_val_next  = 1'b0;
        end else begin
            if (s1_adv) s1_val_next = i_val;
            if (s2_adv) o_val_next  = s1_val_reg;
        end
    end

    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_val_reg <= 1'b0;
            o_val_reg  <= 1'b0;
        end else begin
            s1_val_reg <= s1_val_next;
            o_val_reg  <= o_val_next;
        end
    end

    // Sideband and result registers only load when their stage takes a valid op.
    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_mode_reg <= 2'b00;
            s1_tag_reg  <= '0;
            o_data_reg  <= '0;
            o_tag_reg   <= '0;
        end else begin
            if (in_fire) begin
                s1_mode_reg <= i_mode;
                s1_tag_reg  <= i_tag;
            end
            if (s1_move) begin
                o_data_reg <= res_next;
                o_tag_reg  <= s1_tag_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            logic [3:0] cnt_reg;
            always_ff @(posedge nclk or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg <= '0;
                else if (in_fire)
                    cnt_reg <= 4'($countones(i_data[8*gi +: 8]));
            end
            assign cnt_flat[4*gi +: 4] = cnt_reg;
`ifdef TRI_POPCNT_PRTY_EN
            logic par_reg;
            always_ff @(posedge nclk or negedge rst_n) begin
                if (!rst_n)
                    par_reg <= 1'b0;
                else if (in_fire)
                    par_reg <= i_data[8*gi+7];
            end
            assign par_flat[gi] = par_reg;
`endif
        end

        for (gi = 0; gi < ND; gi++) begin : g_dword
            assign dsum_flat[7*gi +: 7] = 7'(wsum_flat[12*gi +: 6]) + 7'(wsum_flat[12*gi+6 +: 6]);
        end

        for (gi = 0; gi < NW; gi++) begin : g_word
            logic [5:0]  wsum;
            logic [31:0] w;
            assign wsum = 6'(cnt_flat[16*gi +: 4]) + 6'(cnt_flat[16*gi+4 +: 4])
                        + 6'(cnt_flat[16*gi+8 +: 4]) + 6'(cnt_flat[16*gi+12 +: 4]);
            assign wsum_flat[6*gi +: 6] = wsum;

            // The doubleword sum lands in the less significant (odd) word of each pair.
            always_comb begin
                w = '0;
                case (s1_mode_reg)
                    2'b00: w = {4'b0, cnt_flat[16*gi +: 4],   4'b0, cnt_flat[16*gi+4 +: 4],
                                4'b0, cnt_flat[16*gi+8 +: 4], 4'b0, cnt_flat[16*gi+12 +: 4]};
                    2'b01: w = {26'b0, wsum};
                    2'b10: if (gi % 2 == 1) w = {25'b0, dsum_flat[7*(gi/2) +: 7]};
                    default: begin
`ifdef TRI_POPCNT_PRTY_EN
                        w = {31'b0, ^par_flat[4*gi +: 4]};
`endif
                    end
                endcase
            end
            assign res_next[32*gi +: 32] = w;
        end
    endgenerate

    assign o_val  = o_val_reg;
    assign o_data = o_data_reg;
    assign o_tag  = o_tag_reg;
endmodule
